// File: rtl/mmio_hub_pkg.sv
// Shared decode constants, button status layout and target select for the MMIO hub.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mmio_pkg;

  localparam logic [7:0] OFF_SW  = 8'h00;
  localparam logic [7:0] OFF_BTN = 8'h40;
  localparam logic [7:0] OFF_LED = 8'h80;
  localparam logic [7:0] OFF_SEG = 8'hC0;
  localparam logic [7:0] OFF_CNT = 8'hC4;

  typedef struct packed {
    logic [15:0] sticky;
    logic [15:0] level;
  } btn_status_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_SW,
    SEL_BTN,
    SEL_LED,
    SEL_SEG,
    SEL_CNT
  } mmio_sel_e;

endpackage

// File: rtl/mmio_hub_if.sv
// CPU-side load/store port of the MMIO hub; DataIo is combinational read data.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface mmio_hub_if;
  logic [`DATA_WIDTH-1:0] Address;
  logic [`DATA_WIDTH-1:0] WriteData;
  logic                   MemWrite;
  logic                   MemRead;
  logic [`DATA_WIDTH-1:0] DataIo;

  modport master (output Address, WriteData, MemWrite, MemRead, input DataIo);
  modport slave  (input Address, WriteData, MemWrite, MemRead, output DataIo);
endinterface

// File: rtl/mmio_hub_debounce.sv
// One button: 2-flop synchroniser, stability counter, accepted level and a one-cycle
// rise pulse that is high during the cycle whose closing edge flips the level 0->1.
module mmio_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic        s1_q, s2_q, level_q, level_d;
  logic [19:0] cnt_q, cnt_d;
  logic        differ, done;

  assign differ = (s2_q != level_q);
  assign done   = differ && (cnt_q == DEBOUNCE_CYCLES - 20'd1);

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (done)        level_d = ~level_q;
    else if (differ) cnt_d   = cnt_q + 20'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = done && !level_q;

endmodule

// File: rtl/mmio_hub.sv
// MMIO hub: window decode, switch sync, button status with sticky flags, LED/seg registers
// and a loadable cycle counter. Reads are combinational; writes land on the next edge.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mmio_hub
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE            = 32'hffff_ff00,
  parameter int          N_SW            = 2,
  parameter int          SW_WIDTH        = 8,
  parameter int          N_LED           = 3,
  parameter int          LED_WIDTH       = 8,
  parameter int          N_BTN           = 1,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [31:0] SEG_RESET       = 32'h01ab_cdef
) (
  input  logic                         clk,
  input  logic                         reset,
  mmio_hub_if.slave                    bus,
  input  logic [N_SW*SW_WIDTH-1:0]     Switch,
  input  logic [N_BTN-1:0]             Button,
  output logic [N_LED*LED_WIDTH-1:0]   LedOut,
  output logic [`DATA_WIDTH-1:0]       Seg1Out
);

  logic                       in_win;
  logic [7:0]                 off;
  logic [3:0]                 idx;
  mmio_sel_e                  sel;
  logic [N_SW*SW_WIDTH-1:0]   sw_s1_q, sw_s2_q;
  logic [N_LED*LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]                seg_q, seg_d, cnt_q, cnt_d;
  logic [N_BTN-1:0]           sticky_q, sticky_d, btn_level, btn_rise;
  logic                       rd_clr;
  btn_status_t                status;
  logic [31:0]                rdata;
  logic                       unused_addr;

  assign in_win      = (bus.Address[31:8] == BASE[31:8]);
  assign off         = {bus.Address[7:2], 2'b00};
  assign idx         = off[5:2];
  assign unused_addr = ^bus.Address[1:0];

  always_comb begin
    sel = SEL_NONE;
    if (in_win) begin
      if (off[7:6] == OFF_SW[7:6] && {28'd0, idx} < N_SW)        sel = SEL_SW;
      else if (off[7:6] == OFF_LED[7:6] && {28'd0, idx} < N_LED) sel = SEL_LED;
      else if (off == OFF_BTN)                                   sel = SEL_BTN;
      else if (off == OFF_SEG)                                   sel = SEL_SEG;
      else if (off == OFF_CNT)                                   sel = SEL_CNT;
    end
  end

  for (genvar k = 0; k < N_BTN; k++) begin : g_btn
    mmio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (Button[k]),
      .level_o (btn_level[k]),
      .rise_o  (btn_rise[k])
    );
  end

  // A rise on the same edge as a clearing read wins, so the press is not lost.
  assign rd_clr   = bus.MemRead && (sel == SEL_BTN);
  assign sticky_d = (sticky_q & ~{N_BTN{rd_clr}}) | btn_rise;

  always_comb begin
    led_d = led_q;
    seg_d = seg_q;
    cnt_d = cnt_q + 32'd1;
    if (bus.MemWrite) begin
      if (sel == SEL_SEG) seg_d = bus.WriteData;
      if (sel == SEL_CNT) cnt_d = bus.WriteData;
      if (sel == SEL_LED) begin
        for (int j = 0; j < N_LED; j++) begin
          if (idx == j[3:0]) led_d[j*LED_WIDTH +: LED_WIDTH] = bus.WriteData[LED_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      led_q    <= '0;
      seg_q    <= SEG_RESET;
      cnt_q    <= '0;
      sticky_q <= '0;
    end else begin
      sw_s1_q  <= Switch;
      sw_s2_q  <= sw_s1_q;
      led_q    <= led_d;
      seg_q    <= seg_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    status                   = '0;
    status.level[N_BTN-1:0]  = btn_level;
    status.sticky[N_BTN-1:0] = sticky_q;
    rdata                    = '0;
    case (sel)
      SEL_SW: begin
        for (int j = 0; j < N_SW; j++) begin
          if (idx == j[3:0]) rdata[SW_WIDTH-1:0] = sw_s2_q[j*SW_WIDTH +: SW_WIDTH];
        end
      end
      SEL_LED: begin
        for (int j = 0; j < N_LED; j++) begin
          if (idx == j[3:0]) rdata[LED_WIDTH-1:0] = led_q[j*LED_WIDTH +: LED_WIDTH];
        end
      end
      SEL_BTN: rdata = status;
      SEL_SEG: rdata = seg_q;
      SEL_CNT: rdata = cnt_q;
      default: rdata = '0;
    endcase
  end

  assign bus.DataIo = rdata;
  assign LedOut     = led_q;
  assign Seg1Out    = seg_q;

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub with DEBOUNCE_CYCLES=4: vector table plus button/reset sequences.
module tb_mmio_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw;
  logic [0:0]  btn;
  logic [23:0] led;
  logic [31:0] seg;

  mmio_hub_if bus ();

  mmio_hub #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .Switch  (sw),
    .Button  (btn),
    .LedOut  (led),
    .Seg1Out (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [21];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one bus cycle at the falling edge; the expected read is queued, then popped once DataIo settles.
  task automatic bus_cyc(input string nm, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic re, input logic chk, input logic [31:0] exp);
    @(negedge clk);
    bus.Address   = a;
    bus.WriteData = wd;
    bus.MemWrite  = we;
    bus.MemRead   = re;
    if (chk) exp_q.push_back(exp);
    #1;
    if (chk) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard empty", nm);
      end else begin
        check(nm, bus.DataIo, exp_q.pop_front());
      end
    end
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic re, input logic [31:0] exp);
    bus_cyc(nm, a, 32'h0, 1'b0, re, 1'b1, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cyc("idle", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    sw    = '0;
    btn   = '0;
    bus.Address = '0; bus.WriteData = '0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;

    tbl[0]  = '{32'hFFFF_FFC0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h01AB_CDEF};
    tbl[1]  = '{32'hFFFF_FF80, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    tbl[2]  = '{32'hFFFF_FF84, 32'h3C,        1'b1, 1'b0, 1'b1, 32'h0};
    tbl[3]  = '{32'hFFFF_FF84, 32'h0,         1'b0, 1'b0, 1'b1, 32'h3C};
    tbl[4]  = '{32'hFFFF_FF84, 32'hFF,        1'b0, 1'b0, 1'b1, 32'h3C};
    tbl[5]  = '{32'hFFFF_FF84, 32'h0,         1'b0, 1'b0, 1'b1, 32'h3C};
    tbl[6]  = '{32'hFFFF_FF80, 32'h1234_56A5, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[7]  = '{32'hFFFF_FF80, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5};
    tbl[8]  = '{32'hFFFF_FFC0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h01AB_CDEF};
    tbl[9]  = '{32'hFFFF_FFC0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    tbl[10] = '{32'h1000_0080, 32'h77,        1'b1, 1'b0, 1'b1, 32'h0};
    tbl[11] = '{32'hFFFF_FF80, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5};
    tbl[12] = '{32'h1000_00C0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    tbl[13] = '{32'hFFFF_FF08, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    tbl[14] = '{32'hFFFF_FF8C, 32'h55,        1'b1, 1'b0, 1'b1, 32'h0};
    tbl[15] = '{32'hFFFF_FF88, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    tbl[16] = '{32'hFFFF_FF86, 32'h0,         1'b0, 1'b0, 1'b1, 32'h3C};
    tbl[17] = '{32'hFFFF_FF50, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    tbl[18] = '{32'hFFFF_FF88, 32'h1FF,       1'b1, 1'b0, 1'b1, 32'h0};
    tbl[19] = '{32'hFFFF_FF88, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFF};
    tbl[20] = '{32'hFFFF_FF03, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};

    // Reset state
    #2;
    check("rst_seg", seg, 32'h01AB_CDEF);
    check("rst_led", {8'h0, led}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd("cnt_first", 32'hFFFF_FFC4, 1'b0, 32'd1);
    rd("cnt_second", 32'hFFFF_FFC4, 1'b0, 32'd2);

    // Counter load and wrap
    bus_cyc("cnt_load", 32'hFFFF_FFC4, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 32'h0);
    rd("cnt_loaded", 32'hFFFF_FFC4, 1'b0, 32'hFFFF_FFFE);
    rd("cnt_max", 32'hFFFF_FFC4, 1'b0, 32'hFFFF_FFFF);
    rd("cnt_wrap", 32'hFFFF_FFC4, 1'b0, 32'h0);

    // Switch synchroniser latency
    @(negedge clk);
    sw = 16'hA500;
    rd("sw_lat1", 32'hFFFF_FF04, 1'b0, 32'h0);
    rd("sw_lat2", 32'hFFFF_FF04, 1'b0, 32'hA5);
    rd("sw_bank0", 32'hFFFF_FF00, 1'b0, 32'h0);

    for (int i = 0; i < 21; i++)
      bus_cyc($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].re,
              tbl[i].chk, tbl[i].exp);
    check("led_after_tbl", {8'h0, led}, 32'h00FF_3CA5);
    check("seg_after_tbl", seg, 32'hDEAD_BEEF);

    // A 3-cycle glitch never reaches the accepted level
    @(negedge clk); btn = 1'b1;
    idle(2);
    @(negedge clk); btn = 1'b0;
    for (int k = 0; k < 8; k++) rd($sformatf("glitch%0d", k), 32'hFFFF_FF40, 1'b0, 32'h0);

    // Clean press: level and sticky appear on the sixth edge after the press
    @(negedge clk); btn = 1'b1;
    for (int k = 1; k <= 6; k++)
      rd($sformatf("press_e%0d", k), 32'hFFFF_FF40, 1'b0, (k == 6) ? 32'h0001_0001 : 32'h0);
    idle(4);
    @(negedge clk); btn = 1'b0;
    idle(8);
    rd("release_keeps_sticky", 32'hFFFF_FF40, 1'b1, 32'h0001_0000);
    rd("sticky_cleared", 32'hFFFF_FF40, 1'b0, 32'h0);

    // Clearing read on the same edge as a new rise: the flag survives
    @(negedge clk); btn = 1'b1;
    for (int k = 1; k <= 4; k++) rd($sformatf("setclr_e%0d", k), 32'hFFFF_FF40, 1'b0, 32'h0);
    rd("setclr_read", 32'hFFFF_FF40, 1'b1, 32'h0);
    rd("setclr_kept", 32'hFFFF_FF40, 1'b0, 32'h0001_0001);
    @(negedge clk); btn = 1'b0;
    idle(8);
    rd("setclr_clear", 32'hFFFF_FF40, 1'b1, 32'h0001_0000);
    rd("setclr_gone", 32'hFFFF_FF40, 1'b0, 32'h0);

    // Async reset between edges, with the button held through it
    bus_cyc("pre_rst_led", 32'hFFFF_FF84, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3C);
    @(negedge clk);
    btn   = 1'b1;
    reset = 1'b1;
    #1;
    check("arst_led_rd", bus.DataIo, 32'h0);
    check("arst_ledout", {8'h0, led}, 32'h0);
    check("arst_seg", seg, 32'h01AB_CDEF);
    bus.Address = 32'hFFFF_FFC4;
    #1;
    check("arst_cnt", bus.DataIo, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++)
      rd($sformatf("held_e%0d", k), 32'hFFFF_FF40, 1'b0, (k == 6) ? 32'h0001_0001 : 32'h0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
